// File: rtl/project_pkg.sv
// Shared types and constants for the SRAM owner sequencer.
package project_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_LAUNCH,
        S_WAIT
    } seq_state_t;

    localparam int OWNER_DISP       = 0;
    localparam int OWNER_RX         = 1;
    localparam int OWNER_STAGE_BASE = 2;

    // Index width that stays legal when there is only one stage.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_stage_sequencer_stage_pick.sv
// Finds the next unmasked stage in run order, or the first one when 'first' is set.
module stage_pick
    import project_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int DESCENDING = 1,
    parameter int IDX_W      = idx_width(NUM_STAGES)
) (
    input  logic [IDX_W-1:0]      cur_index,
    input  logic                  first,
    input  logic [NUM_STAGES-1:0] skip_mask,
    output logic [IDX_W-1:0]      next_index,
    output logic                  none
);

    // Later loop iterations overwrite earlier ones, so the scan direction
    // is chosen so the last hit is the nearest stage in run order.
    always_comb begin
        next_index = '0;
        none       = 1'b1;
        if (DESCENDING != 0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (!skip_mask[i] && (first || (IDX_W'(i) < cur_index))) begin
                    next_index = IDX_W'(i);
                    none       = 1'b0;
                end
            end
        end else begin
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                if (!skip_mask[i] && (first || (IDX_W'(i) > cur_index))) begin
                    next_index = IDX_W'(i);
                    none       = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sram_stage_sequencer.sv
// SRAM owner sequencer: UART image load with idle timeout, chained decode
// stages with start/done handshakes, then hand-off to the display client.
module sram_stage_sequencer
    import project_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int TIMER_W    = 26,
    parameter int TIMEOUT    = 49999999,
    parameter int DESCENDING = 1,
    localparam int OWNER_W   = $clog2(NUM_STAGES + 2),
    localparam int IDX_W     = idx_width(NUM_STAGES)
) (
    input  logic                           Clock_50,
    input  logic                           Resetn,
    input  logic                           Rx_line,
    output logic                           Rx_initialize,
    output logic                           Rx_enable,
    input  logic [ADDR_W-1:0]              Rx_address,
    input  logic [DATA_W-1:0]              Rx_write_data,
    input  logic                           Rx_we_n,
    output logic [NUM_STAGES-1:0]          Stage_start,
    input  logic [NUM_STAGES-1:0]          Stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0]   Stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0]   Stage_write_data,
    input  logic [NUM_STAGES-1:0]          Stage_we_n,
    input  logic [NUM_STAGES-1:0]          Skip_mask,
    input  logic [ADDR_W-1:0]              Disp_address,
    output logic [ADDR_W-1:0]              SRAM_address,
    output logic [DATA_W-1:0]              SRAM_write_data,
    output logic                           SRAM_we_n,
    output logic [OWNER_W-1:0]             Owner,
    output logic                           Display_enable,
    output logic                           Busy
);

    localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT);

    seq_state_t              state_reg;
    logic [IDX_W-1:0]        index_reg;
    logic [TIMER_W-1:0]      timer_reg;
    logic                    rx_init_reg;
    logic                    rx_enable_reg;
    logic [NUM_STAGES-1:0]   start_reg;
    logic                    disp_en_reg;

    logic [IDX_W-1:0]        pick_index;
    logic                    pick_none;

    logic [ADDR_W-1:0]       stage_addr [NUM_STAGES];
    logic [DATA_W-1:0]       stage_data [NUM_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_slice
            assign stage_addr[gi] = Stage_address[gi*ADDR_W +: ADDR_W];
            assign stage_data[gi] = Stage_write_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // In S_RX the search starts from the head of the run order.
    stage_pick #(
        .NUM_STAGES (NUM_STAGES),
        .DESCENDING (DESCENDING),
        .IDX_W      (IDX_W)
    ) u_stage_pick (
        .cur_index  (index_reg),
        .first      (state_reg == S_RX),
        .skip_mask  (Skip_mask),
        .next_index (pick_index),
        .none       (pick_none)
    );

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_reg     <= S_IDLE;
            index_reg     <= '0;
            timer_reg     <= '0;
            rx_init_reg   <= 1'b0;
            rx_enable_reg <= 1'b0;
            start_reg     <= '0;
            disp_en_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    timer_reg     <= '0;
                    rx_init_reg   <= 1'b0;
                    rx_enable_reg <= 1'b0;
                    if (!Rx_line) begin
                        state_reg   <= S_RX;
                        rx_init_reg <= 1'b1;
                        disp_en_reg <= 1'b0;
                    end
                end
                S_RX: begin
                    rx_init_reg   <= 1'b0;
                    rx_enable_reg <= rx_init_reg;
                    if (timer_reg == TIMEOUT_T) begin
                        timer_reg <= '0;
                        if (pick_none) begin
                            state_reg   <= S_IDLE;
                            disp_en_reg <= 1'b1;
                        end else begin
                            index_reg <= pick_index;
                            state_reg <= S_LAUNCH;
                        end
                    end else if (!Rx_we_n) begin
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    rx_enable_reg <= 1'b0;
                    start_reg     <= NUM_STAGES'(1) << index_reg;
                    state_reg     <= S_WAIT;
                end
                S_WAIT: begin
                    rx_enable_reg <= 1'b0;
                    // Dropping start here leaves the following S_LAUNCH cycle with all starts low.
                    if (Stage_done[index_reg]) begin
                        start_reg <= '0;
                        if (pick_none) begin
                            state_reg   <= S_IDLE;
                            disp_en_reg <= 1'b1;
                        end else begin
                            index_reg <= pick_index;
                            state_reg <= S_LAUNCH;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        SRAM_address    = Disp_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        Owner           = OWNER_W'(OWNER_DISP);
        case (state_reg)
            S_RX: begin
                SRAM_address    = Rx_address;
                SRAM_write_data = Rx_write_data;
                SRAM_we_n       = Rx_we_n;
                Owner           = OWNER_W'(OWNER_RX);
            end
            S_LAUNCH, S_WAIT: begin
                SRAM_address    = stage_addr[index_reg];
                SRAM_write_data = stage_data[index_reg];
                SRAM_we_n       = Stage_we_n[index_reg];
                Owner           = OWNER_W'(OWNER_STAGE_BASE) + OWNER_W'(index_reg);
            end
            default: begin
            end
        endcase
    end

    assign Rx_initialize  = rx_init_reg;
    assign Rx_enable      = rx_enable_reg;
    assign Stage_start    = start_reg;
    assign Display_enable = disp_en_reg;
    assign Busy           = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer with TIMEOUT=20, three descending stages.
module tb_sram_stage_sequencer;

    localparam int NS      = 3;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int OWNER_W = $clog2(NS + 2);

    logic                 Clock_50;
    logic                 Resetn;
    logic                 Rx_line;
    logic                 Rx_initialize;
    logic                 Rx_enable;
    logic [ADDR_W-1:0]    Rx_address;
    logic [DATA_W-1:0]    Rx_write_data;
    logic                 Rx_we_n;
    logic [NS-1:0]        Stage_start;
    logic [NS-1:0]        Stage_done;
    logic [NS*ADDR_W-1:0] Stage_address;
    logic [NS*DATA_W-1:0] Stage_write_data;
    logic [NS-1:0]        Stage_we_n;
    logic [NS-1:0]        Skip_mask;
    logic [ADDR_W-1:0]    Disp_address;
    logic [ADDR_W-1:0]    SRAM_address;
    logic [DATA_W-1:0]    SRAM_write_data;
    logic                 SRAM_we_n;
    logic [OWNER_W-1:0]   Owner;
    logic                 Display_enable;
    logic                 Busy;

    logic [ADDR_W-1:0] st_addr [NS];
    logic [DATA_W-1:0] st_data [NS];
    logic              st_wen  [NS];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  lat;
    bit  watch1    = 0;
    bit  watch_any = 0;
    int  start1_seen    = 0;
    int  any_start_seen = 0;

    sram_stage_sequencer #(
        .NUM_STAGES (NS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMER_W    (26),
        .TIMEOUT    (20),
        .DESCENDING (1)
    ) dut (
        .Clock_50         (Clock_50),
        .Resetn           (Resetn),
        .Rx_line          (Rx_line),
        .Rx_initialize    (Rx_initialize),
        .Rx_enable        (Rx_enable),
        .Rx_address       (Rx_address),
        .Rx_write_data    (Rx_write_data),
        .Rx_we_n          (Rx_we_n),
        .Stage_start      (Stage_start),
        .Stage_done       (Stage_done),
        .Stage_address    (Stage_address),
        .Stage_write_data (Stage_write_data),
        .Stage_we_n       (Stage_we_n),
        .Skip_mask        (Skip_mask),
        .Disp_address     (Disp_address),
        .SRAM_address     (SRAM_address),
        .SRAM_write_data  (SRAM_write_data),
        .SRAM_we_n        (SRAM_we_n),
        .Owner            (Owner),
        .Display_enable   (Display_enable),
        .Busy             (Busy)
    );

    initial Clock_50 = 1'b0;
    always #5 Clock_50 = ~Clock_50;

    always @(posedge Clock_50) begin
        if (watch1 && Stage_start[1]) start1_seen <= start1_seen + 1;
        if (watch_any && (Stage_start != '0)) any_start_seen <= any_start_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge Clock_50);
        #1;
    endtask

    // Starts a load, performs nwr UART writes, then counts edges until the bus leaves the UART.
    task automatic do_load(input int nwr, output int cycles);
        Rx_line = 1'b0;
        tick();
        Rx_line = 1'b1;
        check("rx_init_pulse", Rx_initialize, 1);
        check("load_clears_disp_en", Display_enable, 0);
        check("rx_owner", Owner, 1);
        tick();
        check("rx_init_drop", Rx_initialize, 0);
        check("rx_enable", Rx_enable, 1);
        for (int k = 0; k < nwr; k++) begin
            Rx_address    = 18'h00200 + 18'(k);
            Rx_write_data = 16'h5A00 + 16'(k);
            Rx_we_n       = 1'b0;
            #1;
            check("rx_mux_addr", SRAM_address, 32'h200 + k);
            check("rx_mux_data", SRAM_write_data, 32'h5A00 + k);
            check("rx_mux_we_n", SRAM_we_n, 0);
            tick();
            Rx_we_n = 1'b1;
            if (k != nwr - 1) tick();
        end
        cycles = 0;
        while (Busy && (Owner == OWNER_W'(1)) && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    // Entered on the S_LAUNCH cycle of stage idx; leaves one cycle after its done edge.
    task automatic do_stage(input int idx, input int hold);
        check("launch_start_low", Stage_start, 0);
        check("launch_owner", Owner, 2 + idx);
        tick();
        check("wait_start", Stage_start, 1 << idx);
        check("stage_mux_addr", SRAM_address, st_addr[idx]);
        check("stage_mux_data", SRAM_write_data, st_data[idx]);
        check("stage_mux_we_n", SRAM_we_n, st_wen[idx]);
        repeat (hold) tick();
        check("start_held", Stage_start, 1 << idx);
        Stage_done      = '0;
        Stage_done[idx] = 1'b1;
        tick();
        Stage_done = '0;
        check("done_drops_start", Stage_start, 0);
    endtask

    initial begin
        st_addr[0] = 18'h00100; st_addr[1] = 18'h12345; st_addr[2] = 18'h20002;
        st_data[0] = 16'hAA00;  st_data[1] = 16'hBB11;  st_data[2] = 16'hCC22;
        st_wen[0]  = 1'b1;      st_wen[1]  = 1'b0;      st_wen[2]  = 1'b1;
        Stage_address    = {st_addr[2], st_addr[1], st_addr[0]};
        Stage_write_data = {st_data[2], st_data[1], st_data[0]};
        Stage_we_n       = {st_wen[2], st_wen[1], st_wen[0]};
        Resetn        = 1'b0;
        Rx_line       = 1'b1;
        Rx_address    = '0;
        Rx_write_data = '0;
        Rx_we_n       = 1'b1;
        Stage_done    = '0;
        Skip_mask     = '0;
        Disp_address  = 18'h00ABC;

        repeat (3) @(posedge Clock_50);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_owner", Owner, 0);
        check("rst_start", Stage_start, 0);
        check("rst_disp_en", Display_enable, 0);
        check("rst_rx_init", Rx_initialize, 0);
        check("rst_rx_enable", Rx_enable, 0);
        check("rst_sram_addr", SRAM_address, 32'hABC);
        Resetn = 1'b1;
        tick();
        tick();
        check("idle_hold", Busy, 0);

        // Full chain, no mask: 2, 1, 0.
        do_load(5, lat);
        check("timeout_latency", lat, 21);
        do_stage(2, 2);
        do_stage(1, 0);
        do_stage(0, 3);
        check("chain_disp_en", Display_enable, 1);
        check("chain_owner", Owner, 0);
        check("chain_busy", Busy, 0);
        check("idle_mux_addr", SRAM_address, 32'hABC);
        check("idle_mux_we_n", SRAM_we_n, 1);
        check("idle_mux_data", SRAM_write_data, 0);

        // Stage 1 masked: 2 then 0.
        Skip_mask = 3'b010;
        watch1    = 1'b1;
        do_load(2, lat);
        check("mask010_latency", lat, 21);
        do_stage(2, 1);
        do_stage(0, 1);
        watch1 = 1'b0;
        check("mask010_disp_en", Display_enable, 1);
        check("mask010_stage1_never", start1_seen, 0);

        // All masked: straight back to idle on the timeout edge.
        Skip_mask = 3'b111;
        watch_any = 1'b1;
        do_load(1, lat);
        check("mask111_latency", lat, 21);
        check("mask111_busy", Busy, 0);
        check("mask111_disp_en", Display_enable, 1);
        check("mask111_owner", Owner, 0);
        tick();
        tick();
        watch_any = 1'b0;
        check("mask111_no_start", any_start_seen, 0);

        // Done ignored in S_LAUNCH and for non-active stages.
        Skip_mask = 3'b000;
        do_load(1, lat);
        check("ign_latency", lat, 21);
        check("ign_launch_owner", Owner, 4);
        Stage_done = 3'b101;
        tick();
        check("ign_launch_done", Stage_start, 3'b100);
        Stage_done = 3'b001;
        repeat (3) tick();
        check("ign_other_done", Stage_start, 3'b100);
        check("ign_owner_held", Owner, 4);
        Stage_done = 3'b101;
        tick();
        Stage_done = 3'b000;
        check("ign_advance_start", Stage_start, 0);
        do_stage(1, 0);
        do_stage(0, 0);
        check("ign_disp_en", Display_enable, 1);

        // Asynchronous reset while a stage is running.
        do_load(1, lat);
        check("arst_latency", lat, 21);
        tick();
        check("arst_pre_start", Stage_start, 3'b100);
        #2;
        Resetn = 1'b0;
        #1;
        check("arst_start", Stage_start, 0);
        check("arst_busy", Busy, 0);
        check("arst_owner", Owner, 0);
        check("arst_disp_en", Display_enable, 0);
        repeat (2) @(posedge Clock_50);
        #1;
        Resetn = 1'b1;
        repeat (4) tick();
        check("arst_idle_wait", Busy, 0);
        Rx_line = 1'b0;
        tick();
        Rx_line = 1'b1;
        check("arst_reload_busy", Busy, 1);
        check("arst_reload_owner", Owner, 1);
        check("arst_reload_init", Rx_initialize, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
